// File: rtl/ps2_keycode_rx_if.sv
// PS/2 receiver bus: the two raw pins that enter the receiver and the keycode it presents.
interface ps2_keycode_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] keycode;
  logic        keycode_valid;
  logic        frame_err;

  // Receiver side: samples the pins and drives the keycode bus.
  modport master (
    input  ps2_clk,
    input  ps2_data,
    output keycode,
    output keycode_valid,
    output frame_err
  );

  // Keyboard/consumer side: drives the pins and observes the keycode bus.
  modport slave (
    output ps2_clk,
    output ps2_data,
    input  keycode,
    input  keycode_valid,
    input  frame_err
  );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the pins, deserialises
// 11-bit frames and shifts each good byte into a 16-bit {prev, last} keycode.
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic             clk,
  input  logic             rst,
  ps2_keycode_rx_if.master bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt, clk_filt_q;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic          stop_bit;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   keycode_q;
  logic          valid_q, err_q;

  // Two-flop synchronisers for both pins; idle PS/2 lines are high.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= bus.ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= bus.ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Glitch filter: the filtered clock flips only after FILTER_LEN consecutive
  // samples that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_q <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FLT_MAX) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_q & ~clk_filt;

  // Frame FSM with registered keycode and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      stop_bit  <= 1'b0;
      tmo_cnt   <= '0;
      keycode_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          // A fall with data high is line noise and is silently ignored.
          if (fall && !data_s2) begin
            state   <= RECV;
            bit_cnt <= '0;
            tmo_cnt <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            tmo_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              stop_bit <= data_s2;
              state    <= CHECK;
            end else begin
              // LSB first: after nine shifts shreg = {parity, d7..d0}.
              shreg   <= {data_s2, shreg[8:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (tmo_cnt == TMO_MAX) begin
            state   <= IDLE;
            bit_cnt <= '0;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (stop_bit && (^shreg)) begin
            keycode_q <= {keycode_q[7:0], shreg[7:0]};
            valid_q   <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          bit_cnt <= '0;
          // A start bit landing in this cycle begins the next frame directly.
          if (fall && !data_s2) begin
            state   <= RECV;
            tmo_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.keycode       = keycode_q;
  assign bus.keycode_valid = valid_q;
  assign bus.frame_err     = err_q;

endmodule
